// File: rtl/mic_sampler_if.sv
// rtl/mic_sampler_if.sv - strobe, SPI and sample-output signals of mic_sampler
interface mic_sampler_if #(
  parameter int DATA_BITS = 12
);
  logic                 clkSample;
  logic                 spiMiso;
  logic                 spiSclk;
  logic                 spiCs_n;
  logic [DATA_BITS-1:0] sample;
  logic                 sampleValid;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  clkSample,
    input  spiMiso,
    output spiSclk,
    output spiCs_n,
    output sample,
    output sampleValid,
    output busy,
    output overrun
  );

  modport slave (
    output clkSample,
    output spiMiso,
    input  spiSclk,
    input  spiCs_n,
    input  sample,
    input  sampleValid,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/mic_sampler.sv
// rtl/mic_sampler.sv - SPI reader for the 12-bit mic ADC, one frame per clkSample strobe
// Defining MIC_SAMPLER_FRAMECHK_EN adds the frameErr output (non-zero leading frame bits).
module mic_sampler #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12
) (
  input  logic          sysClk,
  input  logic          rst,
  mic_sampler_if.master bus
`ifdef MIC_SAMPLER_FRAMECHK_EN
  ,
  output logic          frameErr
`endif
);

  localparam int SHIFT_W = DATA_BITS + 4;
  localparam int HALF_W  = $clog2(2 * FRAME_BITS);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [HALF_W-1:0]    half_q, half_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 div_last;
`ifdef MIC_SAMPLER_FRAMECHK_EN
  logic                 ferr_q, ferr_d;
`endif

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q;
`ifdef MIC_SAMPLER_FRAMECHK_EN
    ferr_d   = 1'b0;
`endif

    // Any strobe outside IDLE is lost, including the one on the CS_HOLD->IDLE edge
    if (bus.clkSample && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.clkSample) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          div_d   = 8'd0;
          half_d  = '0;
          shift_d = '0;
        end
      end
      CS_SETUP: begin
        if (div_last) begin
          div_d   = 8'd0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_d  = 8'd0;
          half_d = half_q + 1'b1;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[SHIFT_W-2:0], bus.spiMiso};
          end else if (half_q == HALF_LAST) begin
            state_d = CS_HOLD;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      CS_HOLD: begin
        if (div_last) begin
          div_d    = 8'd0;
          cs_n_d   = 1'b1;
          sample_d = shift_q[DATA_BITS-1:0];
          valid_d  = 1'b1;
          state_d  = IDLE;
`ifdef MIC_SAMPLER_FRAMECHK_EN
          ferr_d   = |shift_q[SHIFT_W-1:DATA_BITS];
`endif
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= 8'd0;
      half_q   <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      shift_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef MIC_SAMPLER_FRAMECHK_EN
  always_ff @(posedge sysClk) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign frameErr = ferr_q;
`endif

  assign bus.spiSclk     = sclk_q;
  assign bus.spiCs_n     = cs_n_q;
  assign bus.sample      = sample_q;
  assign bus.sampleValid = valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_mic_sampler.sv
// tb/tb_mic_sampler.sv - randomized self-checking bench for mic_sampler against a cycle-level frame model
module tb_mic_sampler;

  localparam int CD        = 4;
  localparam int FRAME_CYC = 34 * CD;
  localparam int NO_FRAME  = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mic_sampler_if #(.DATA_BITS(12)) bus ();
`ifdef MIC_SAMPLER_FRAMECHK_EN
  logic frame_err;
`endif

  mic_sampler #(
    .CLK_DIV   (CD),
    .FRAME_BITS(16),
    .DATA_BITS (12)
  ) dut (
    .sysClk(clk),
    .rst   (rst),
    .bus   (bus)
`ifdef MIC_SAMPLER_FRAMECHK_EN
    ,
    .frameErr(frame_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC: word presented MSB first, one bit per SCLK rise counted since CS fell
  logic [15:0] adc_word = 16'h0000;
  int          bit_k = 16;
  always @(negedge bus.spiCs_n) bit_k = 0;
  always @(posedge bus.spiSclk) bit_k = bit_k + 1;
  assign bus.spiMiso = (bit_k >= 0 && bit_k < 16) ? adc_word[15 - bit_k] : 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame model: a frame accepted at edge last_acc owns cycles [last_acc, last_acc+34*CD)
  int          last_acc = NO_FRAME;
  logic        pend = 1'b0;
  logic [15:0] pend_word = 16'h0;
  logic [11:0] exp_sample = 12'h0;
  logic        exp_ovr = 1'b0;
  logic        mon_en = 1'b0;
  int          valid_cnt = 0;
  int          last_valid_cyc = -1;
  logic        last_fe = 1'b0;

  logic exp_v, exp_fe, exp_busy, exp_sclk;
  int   rel;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v  = pend && (cyc == last_acc + FRAME_CYC);
      exp_fe = 1'b0;
      if (exp_v) begin
        exp_sample = pend_word[11:0];
        exp_fe     = |pend_word[15:12];
        pend       = 1'b0;
      end
      exp_busy = (cyc >= last_acc) && (cyc < last_acc + FRAME_CYC);
      exp_sclk = 1'b1;
      if (exp_busy) begin
        rel = cyc - last_acc;
        if (rel >= CD && rel < 33 * CD) exp_sclk = (((rel - CD) / CD) % 2) == 1;
      end
      check("sampleValid", bus.sampleValid, exp_v);
      check("sample", bus.sample, exp_sample);
      check("busy", bus.busy, exp_busy);
      check("spiCs_n", bus.spiCs_n, !exp_busy);
      check("spiSclk", bus.spiSclk, exp_sclk);
      check("overrun", bus.overrun, exp_ovr);
`ifdef MIC_SAMPLER_FRAMECHK_EN
      check("frameErr", frame_err, exp_fe);
      if (bus.sampleValid) last_fe = frame_err;
`endif
      if (bus.sampleValid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic goto_edge(input int t);
    while (cyc < t - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] w);
    int   e;
    logic ok;
    @(negedge clk);
    e  = cyc + 1;
    ok = (e > last_acc + FRAME_CYC);
    if (ok) adc_word = w;
    bus.clkSample = 1'b1;
    @(posedge clk);
    #1;
    bus.clkSample = 1'b0;
    if (ok) begin
      last_acc  = e;
      pend      = 1'b1;
      pend_word = w;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    last_acc   = NO_FRAME;
    pend       = 1'b0;
    exp_sample = 12'h0;
    exp_ovr    = 1'b0;
  endtask

  task automatic settle();
    goto_edge(cyc + FRAME_CYC + 6);
  endtask

  logic [15:0] words [3] = '{16'h0000, 16'h0FFF, 16'h0800};
  int          v0, s, base;
  logic [15:0] w;

  initial begin
    bus.clkSample = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_sclk", bus.spiSclk, 1'b1);
    check("rst_cs_n", bus.spiCs_n, 1'b1);
    check("rst_sample", bus.sample, 12'h0);

    // Single frame, exact latency
    goto_edge(10);
    strobe(16'h0A5C);
    goto_edge(152);
    check("t1_valid_cycle", last_valid_cyc, 146);
    check("t1_sample", bus.sample, 12'hA5C);
    check("t1_valid_count", valid_cnt, 1);

    // Back-to-back at the nominal sample spacing
    base = 200;
    v0   = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      goto_edge(base + i * 2268);
      strobe(words[i]);
      goto_edge(base + i * 2268 + FRAME_CYC + 2);
      check("t2_sample", bus.sample, {20'h0, words[i][11:0]});
    end
    check("t2_valid_count", valid_cnt - v0, 3);
    check("t2_no_overrun", bus.overrun, 1'b0);

    // Strobe 50 cycles into a frame is dropped
    v0 = valid_cnt;
    strobe(16'h0123);
    s = last_acc;
    goto_edge(s + 50);
    strobe(16'h0FFF);
    settle();
    check("t3_sample", bus.sample, 12'h123);
    check("t3_overrun", bus.overrun, 1'b1);
    check("t3_valid_count", valid_cnt - v0, 1);

    // Reset during the 7th SCLK high phase
    v0 = valid_cnt;
    strobe(16'h0456);
    goto_edge(last_acc + 14 * CD + 1);
    do_reset();
    check("t4_cs_n", bus.spiCs_n, 1'b1);
    check("t4_sclk", bus.spiSclk, 1'b1);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_overrun", bus.overrun, 1'b0);
    settle();
    check("t4_no_valid", valid_cnt - v0, 0);
    strobe(16'h0789);
    settle();
    check("t4_after_sample", bus.sample, 12'h789);

    // Strobe on the sampleValid edge is dropped; the next cycle is accepted
    strobe(16'h0321);
    s = last_acc;
    goto_edge(s + FRAME_CYC);
    strobe(16'h0654);
    check("t5_edge_overrun", bus.overrun, 1'b1);
    strobe(16'h0987);
    check("t5_next_busy", bus.busy, 1'b1);
    settle();
    check("t5_sample", bus.sample, 12'h987);

`ifdef MIC_SAMPLER_FRAMECHK_EN
    strobe(16'h8123);
    settle();
    check("t6_sample", bus.sample, 12'h123);
    check("t6_frameErr", last_fe, 1'b1);
    strobe(16'h0123);
    settle();
    check("t6_clean_frameErr", last_fe, 1'b0);
`endif

    // Random strobes, words (leading bits included) and occasional resets
    for (int i = 0; i < 40; i++) begin
      goto_edge(cyc + $urandom_range(1, 180));
      if ($urandom_range(0, 9) == 0) begin
        do_reset();
      end else begin
        w = 16'($urandom);
        strobe(w);
      end
    end
    settle();
    check("final_idle", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
